// File: rtl/time_set_ctrl_pkg.sv
// Shared types, button/field indices and per-field limits for the time-setting controller.
package time_set_pkg;

    typedef enum logic [1:0] {StIdle, StSet, StCommit} state_e;

    localparam int unsigned BtnDown = 0;
    localparam int unsigned BtnUp   = 1;
    localparam int unsigned BtnInc  = 2;
    localparam int unsigned BtnDec  = 3;

    localparam int unsigned FldSec   = 0;
    localparam int unsigned FldMin   = 1;
    localparam int unsigned FldHour  = 2;
    localparam int unsigned FldDay   = 3;
    localparam int unsigned FldMonth = 4;
    localparam int unsigned FldYear  = 5;

    function automatic int unsigned field_min(input int unsigned idx);
        case (idx)
            FldDay, FldMonth: field_min = 1;
            default:          field_min = 0;
        endcase
    endfunction

    // Fields beyond year span the full FW-bit range.
    function automatic int unsigned field_max(input int unsigned idx, input int unsigned fw);
        case (idx)
            FldSec, FldMin: field_max = 59;
            FldHour:        field_max = 23;
            FldDay:         field_max = 31;
            FldMonth:       field_max = 12;
            FldYear:        field_max = 99;
            default:        field_max = (fw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << fw) - 32'd1);
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bundle of the user inputs, running time and edited-time outputs of time_set_ctrl.
interface time_set_ctrl_if #(
    parameter int unsigned FIELDS = 6,
    parameter int unsigned FW     = 8,
    parameter int unsigned CW     = $clog2(FIELDS)
) ();
    logic [1:0]           dip_sw;
    logic [3:0]           sw_in;
    logic [FIELDS*FW-1:0] bin_time;
    logic                 en_time;
    logic [CW-1:0]        cursor;
    logic [FIELDS*FW-1:0] set_time;
    logic                 load;

    modport master (
        output dip_sw, sw_in, bin_time,
        input  en_time, cursor, set_time, load
    );

    modport slave (
        input  dip_sw, sw_in, bin_time,
        output en_time, cursor, set_time, load
    );
endinterface

// File: rtl/time_set_ctrl_field_stepper.sv
// Combinational wrap-around increment/decrement of one field against its [min,max] limits.
module field_stepper #(
    parameter int unsigned FW = 8
) (
    input  logic [FW-1:0] val_i,
    input  logic [FW-1:0] min_i,
    input  logic [FW-1:0] max_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [FW-1:0] val_o
);
    always_comb begin
        val_o = val_i;
        if (inc_i && !dec_i) begin
            val_o = (val_i >= max_i) ? min_i : val_i + 1'b1;
        end else if (dec_i && !inc_i) begin
            val_o = (val_i <= min_i) ? max_i : val_i - 1'b1;
        end
    end
endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: freezes a shadow of the running time, edits it field by field,
// then commits it with a one-cycle load strobe or discards it.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned FIELDS = 6,
    parameter int unsigned FW     = 8,
    parameter int unsigned CW     = $clog2(FIELDS)
) (
    input logic            clk,
    input logic            rst,
    time_set_ctrl_if.slave bus
);
    state_e               state_q, state_d;
    logic [FIELDS*FW-1:0] shadow_q, shadow_d;
    logic [CW-1:0]        cursor_q, cursor_d;
    logic                 en_q, en_d;
    logic                 load_q, load_d;
    logic [3:0]           sw_prev_q, sw_prev_d;

    logic [3:0]           sw_rise;
    logic [FIELDS*FW-1:0] entry_time;
    logic [FW-1:0]        cur_field, cur_min, cur_max, stepped;

    assign sw_rise   = bus.sw_in & ~sw_prev_q;
    assign sw_prev_d = bus.sw_in;
    assign cur_field = shadow_q[cursor_q*FW +: FW];
    assign cur_min   = FW'(field_min(32'(cursor_q)));
    assign cur_max   = FW'(field_max(32'(cursor_q), FW));

    // Out-of-range captured fields are forced to their minimum.
    always_comb begin
        logic [FW-1:0] fv;
        entry_time = '0;
        for (int unsigned i = 0; i < FIELDS; i++) begin
            fv = bus.bin_time[i*FW +: FW];
            if (fv < FW'(field_min(i)) || fv > FW'(field_max(i, FW))) begin
                fv = FW'(field_min(i));
            end
            entry_time[i*FW +: FW] = fv;
        end
    end

    field_stepper #(.FW(FW)) u_stepper (
        .val_i (cur_field),
        .min_i (cur_min),
        .max_i (cur_max),
        .inc_i (sw_rise[BtnInc]),
        .dec_i (sw_rise[BtnDec]),
        .val_o (stepped)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cursor_d = cursor_q;
        en_d     = en_q;
        load_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.dip_sw[0]) begin
                    state_d  = StSet;
                    en_d     = 1'b1;
                    cursor_d = '0;
                    shadow_d = entry_time;
                end
            end
            StSet: begin
                if (!bus.dip_sw[0]) begin
                    en_d = 1'b0;
                    if (bus.dip_sw[1]) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StCommit;
                        load_d  = 1'b1;
                    end
                end else begin
                    // Stepper works on the pre-move cursor, so a same-cycle move is harmless.
                    shadow_d[cursor_q*FW +: FW] = stepped;
                    if (sw_rise[BtnUp] && !sw_rise[BtnDown]) begin
                        cursor_d = (cursor_q == CW'(FIELDS - 1)) ? '0 : cursor_q + 1'b1;
                    end else if (sw_rise[BtnDown] && !sw_rise[BtnUp]) begin
                        cursor_d = (cursor_q == '0) ? CW'(FIELDS - 1) : cursor_q - 1'b1;
                    end
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            cursor_q  <= '0;
            en_q      <= 1'b0;
            load_q    <= 1'b0;
            sw_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cursor_q  <= cursor_d;
            en_q      <= en_d;
            load_q    <= load_d;
            sw_prev_q <= sw_prev_d;
        end
    end

    assign bus.en_time  = en_q;
    assign bus.cursor   = cursor_q;
    assign bus.set_time = shadow_q;
    assign bus.load     = load_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: per-cycle comparison against a field-array model plus literal checks.
module tb_time_set_ctrl;
    localparam int unsigned FIELDS = 6;
    localparam int unsigned FW     = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    time_set_ctrl_if #(.FIELDS(FIELDS), .FW(FW)) bus ();

    time_set_ctrl #(.FIELDS(FIELDS), .FW(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: editing mode, six field values, cursor and the two strobes.
    int          lo [FIELDS] = '{0, 0, 0, 1, 1, 0};
    int          hi [FIELDS] = '{59, 59, 23, 31, 12, 99};
    int          m_mode;  // 0 idle, 1 editing, 2 committing
    int          m_f [FIELDS];
    int          m_cur;
    logic [3:0]  m_prev;
    logic [47:0] m_time;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        logic [3:0] rise;
        int v;
        if (!rst) begin
            m_mode = 0;
            m_cur  = 0;
            m_prev = '0;
            for (int i = 0; i < FIELDS; i++) m_f[i] = 0;
        end else begin
            rise   = bus.sw_in & ~m_prev;
            m_prev = bus.sw_in;
            if (m_mode == 0) begin
                if (bus.dip_sw[0]) begin
                    m_mode = 1;
                    m_cur  = 0;
                    for (int i = 0; i < FIELDS; i++) begin
                        v = int'(bus.bin_time[i*8 +: 8]);
                        m_f[i] = (v < lo[i] || v > hi[i]) ? lo[i] : v;
                    end
                end
            end else if (m_mode == 1) begin
                if (!bus.dip_sw[0]) begin
                    m_mode = bus.dip_sw[1] ? 0 : 2;
                end else begin
                    if (rise[2] && !rise[3])
                        m_f[m_cur] = (m_f[m_cur] == hi[m_cur]) ? lo[m_cur] : m_f[m_cur] + 1;
                    else if (rise[3] && !rise[2])
                        m_f[m_cur] = (m_f[m_cur] == lo[m_cur]) ? hi[m_cur] : m_f[m_cur] - 1;
                    if (rise[1] && !rise[0]) m_cur = (m_cur + 1) % FIELDS;
                    else if (rise[0] && !rise[1]) m_cur = (m_cur + FIELDS - 1) % FIELDS;
                end
            end else begin
                m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < FIELDS; i++) m_time[i*8 +: 8] = 8'(m_f[i]);
        check("model_en_time", 64'(bus.en_time), 64'(m_mode == 1));
        check("model_load", 64'(bus.load), 64'(m_mode == 2));
        check("model_cursor", 64'(bus.cursor), 64'(m_cur));
        check("model_set_time", 64'(bus.set_time), 64'(m_time));
    end

    task automatic press(input logic [3:0] b);
        bus.sw_in = b;
        @(negedge clk);
        bus.sw_in = '0;
        @(negedge clk);
    endtask

    initial begin
        bus.dip_sw   = 2'b00;
        bus.sw_in    = '0;
        bus.bin_time = 48'h63_0C_1F_17_3B_3B;
        repeat (2) @(negedge clk);
        check("reset_set_time", 64'(bus.set_time), 64'h0);
        check("reset_en_time", 64'(bus.en_time), 64'h0);
        rst = 1'b1;
        @(negedge clk);

        bus.dip_sw = 2'b01;
        @(negedge clk);
        check("entry_en_time", 64'(bus.en_time), 64'h1);
        check("entry_capture", 64'(bus.set_time), 64'h63_0C_1F_17_3B_3B);
        check("entry_cursor", 64'(bus.cursor), 64'h0);

        press(4'b0100);
        check("sec_inc_wrap", 64'(bus.set_time[7:0]), 64'd0);
        press(4'b1000);
        check("sec_dec_wrap", 64'(bus.set_time[7:0]), 64'd59);
        bus.sw_in = 4'b0100;
        repeat (10) @(negedge clk);
        bus.sw_in = '0;
        @(negedge clk);
        check("held_inc_once", 64'(bus.set_time[7:0]), 64'd0);

        press(4'b0001);
        check("cursor_down_wrap", 64'(bus.cursor), 64'd5);
        press(4'b0100);
        check("year_inc_wrap", 64'(bus.set_time[47:40]), 64'd0);
        press(4'b0001);
        for (int i = 0; i < 11; i++) press(4'b1000);
        check("month_at_min", 64'(bus.set_time[39:32]), 64'd1);
        press(4'b1000);
        check("month_dec_wrap", 64'(bus.set_time[39:32]), 64'd12);
        press(4'b0001);
        press(4'b0100);
        check("day_inc_wrap", 64'(bus.set_time[31:24]), 64'd1);
        press(4'b1000);
        check("day_dec_wrap", 64'(bus.set_time[31:24]), 64'd31);

        press(4'b0011);
        check("up_down_same", 64'(bus.cursor), 64'd3);
        press(4'b1100);
        check("inc_dec_same", 64'(bus.set_time[31:24]), 64'd31);
        press(4'b0110);
        check("inc_up_field", 64'(bus.set_time[31:24]), 64'd1);
        check("inc_up_cursor", 64'(bus.cursor), 64'd4);

        bus.dip_sw = 2'b00;
        @(negedge clk);
        check("commit_load", 64'(bus.load), 64'h1);
        check("commit_en_time", 64'(bus.en_time), 64'h0);
        check("commit_set_time", 64'(bus.set_time), 64'h00_0C_01_17_3B_00);
        @(negedge clk);
        check("commit_load_drop", 64'(bus.load), 64'h0);

        bus.bin_time = 48'h01_02_03_04_05_06;
        bus.dip_sw   = 2'b01;
        @(negedge clk);
        check("reentry_capture", 64'(bus.set_time), 64'h01_02_03_04_05_06);
        press(4'b0100);
        bus.dip_sw = 2'b11;
        @(negedge clk);
        bus.dip_sw = 2'b10;
        @(negedge clk);
        check("discard_en_time", 64'(bus.en_time), 64'h0);
        check("discard_load", 64'(bus.load), 64'h0);
        @(negedge clk);
        check("discard_no_load", 64'(bus.load), 64'h0);
        bus.dip_sw = 2'b00;
        @(negedge clk);

        bus.dip_sw = 2'b01;
        @(negedge clk);
        press(4'b0100);
        #2 rst = 1'b0;
        #1;
        check("rst_set_time", 64'(bus.set_time), 64'h0);
        check("rst_en_time", 64'(bus.en_time), 64'h0);
        check("rst_load", 64'(bus.load), 64'h0);
        bus.dip_sw = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.bin_time = 48'h05_0D_00_03_02_46;
        @(negedge clk);
        bus.dip_sw = 2'b01;
        @(negedge clk);
        check("recapture_clamp", 64'(bus.set_time), 64'h05_01_01_03_02_00);
        check("recapture_cursor", 64'(bus.cursor), 64'h0);
        bus.dip_sw = 2'b00;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Parametrised time-setting controller for the watch datapath. It sits between the debounced button and DIP-switch inputs and the time-keeping counter. On request it freezes a shadow copy of the running time and lets the user pick a field with a cursor and step it up or down, with per-field wrap-around. On exit it commits the edited time with a one-cycle load strobe or discards it.

## Interface
Parameters:
- FIELDS, 6: number of time fields; index 0 = seconds, rising to index 5 = year.
- FW, 8: width of each binary field.
- CW, $clog2(FIELDS): cursor width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-low.
- dip_sw  in  2  [0] = set-mode request (level); [1] = discard on exit (level).
- sw_in  in  4  debounced buttons, active-high: [0] cursor down, [1] cursor up, [2] increment, [3] decrement.
- bin_time  in  FIELDS*FW  running time; field i at [i*FW +: FW].
- en_time  out  1  high while in SET; the counter halts on it.
- cursor  out  CW  index of the selected field.
- set_time  out  FIELDS*FW  shadow (edited) time.
- load  out  1  one-cycle commit strobe; set_time is valid in the same cycle.

## Operation
- FSM states are IDLE, SET and COMMIT.
- IDLE → SET when dip_sw[0]=1:
  - shadow <= bin_time
  - cursor <= 0
  - en_time <= 1
- SET → COMMIT when dip_sw[0]=0 and dip_sw[1]=0.
- SET → IDLE when dip_sw[0]=0 and dip_sw[1]=1; the edit is discarded and load is not asserted.
- COMMIT → IDLE unconditionally. load=1 only in COMMIT; en_time=0 in COMMIT.
- Buttons are rising-edge detected against a registered copy sw_prev.
  - sw_prev updates every cycle in every state.
  - Edges are acted on only in SET.
  - Edges in the IDLE→SET entry cycle are ignored.
- Cursor moves:
  - up: FIELDS-1 wraps to 0.
  - down: 0 wraps to FIELDS-1.
  - up and down edges in the same cycle: no move.
- Increment/decrement act on shadow field[cursor], using the cursor value before any same-cycle cursor move.
  - Increment: max wraps to min.
  - Decrement: min wraps to max.
  - Increment and decrement in the same cycle: no change.
- Field limits [min,max], from package functions:
  - sec 0..59, min 0..59, hour 0..23, day 1..31, month 1..12, year 0..99.
  - Indices ≥6: 0..2^FW-1.
  - No month-aware day check.
- On entry, a shadow field outside its limits is forced to min.
- Arithmetic is FW-bit unsigned. Overflow is never relied on; wrap is by explicit compare.
- set_time always drives the shadow register.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - en_time 0, load 0
  - cursor 0
  - set_time 0
  - sw_prev 0
- Entry: dip_sw[0] high at edge k gives en_time=1 and shadow=bin_time(k) after edge k.
- Button: sw_in rising sampled at edge k in SET gives the update visible after edge k. There is zero added latency and one action per press, however long the button is held.
- Exit: dip_sw[0] low at edge k gives load=1 for cycle k..k+1, then 0. en_time drops after edge k.
- Reset asserted mid-SET returns everything to reset values immediately; no load is issued.

## Structure
- Package time_set_pkg holds:
  - the state enum (IDLE, SET, COMMIT)
  - button index constants
  - field index constants
  - field_min(i) and field_max(i)
- One sub-module, field_stepper: a combinational wrap-around inc/dec of one FW-bit value against min/max. It is instanced once, muxed by cursor.

## Test plan
- Reset then bin_time=sec 59/min 59/hour 23/day 31/month 12/year 99, dip_sw=01 → en_time=1, set_time equals bin_time, cursor=0.
- In SET, cursor 0, one increment press → sec 59→0. One decrement press → sec 0→59. Holding increment for 10 cycles steps only once.
- Cursor down at 0 → cursor=5. Increment on year 99 → 0. Decrement on month (cursor 4) at 1 → 12. Day at 1 decrement → 31.
- Up and down in the same cycle → cursor unchanged. Increment and decrement in the same cycle → field unchanged. Increment plus cursor up in the same cycle → old field incremented, cursor+1.
- dip_sw 01→00 → load high exactly 1 cycle with edited set_time, en_time=0. dip_sw 11→10 → no load, state IDLE.
- Assert rst mid-SET after edits → all outputs 0, IDLE; a later entry recaptures bin_time.
